// File: rtl/se_pkg.sv
// Shared constants and FSM encoding for the SE multiplier operand feeder.
package se_pkg;

  localparam int BITSIZE       = 14;
  localparam int FRAC_BITS     = 7;
  localparam int NUM_INSTANCES = 16;
  localparam int ADDR_W        = 13;

  localparam int VEC_W  = BITSIZE * NUM_INSTANCES;
  localparam int FIFO_W = 2 * VEC_W + ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/se_skid_fifo.sv
// Two-entry skid FIFO parking SRAM returns while the multiplier stalls.
module se_skid_fifo
  import se_pkg::*;
#(
  parameter int W = FIFO_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  // A push into a full FIFO is only accepted when a pop frees a slot on the same edge.
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/se_mul_feeder.sv
// Operand feeder: reads feature/weight vectors from SRAM and streams them into the SE multiplier.
module se_mul_feeder #(
  parameter int BITSIZE       = se_pkg::BITSIZE,
  parameter int NUM_INSTANCES = se_pkg::NUM_INSTANCES,
  parameter int ADDR_W        = se_pkg::ADDR_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             go,
  input  logic [ADDR_W-1:0]                num_vec,
  input  logic [ADDR_W-1:0]                fm_base,
  input  logic [ADDR_W-1:0]                w_base,
  input  logic                             hold,
  output logic                             busy,
  output logic                             done,
  output logic                             fm_rd_en,
  output logic [ADDR_W-1:0]                fm_rd_addr,
  input  logic [BITSIZE*NUM_INSTANCES-1:0] fm_rd_data,
  output logic                             w_rd_en,
  output logic [ADDR_W-1:0]                w_rd_addr,
  input  logic [BITSIZE*NUM_INSTANCES-1:0] w_rd_data,
  output logic [BITSIZE*NUM_INSTANCES-1:0] data_out,
  output logic [BITSIZE*NUM_INSTANCES-1:0] weights_out,
  output logic                             start_flag,
  output logic [ADDR_W-1:0]                in_address
);
  import se_pkg::*;

  localparam int V_W = BITSIZE * NUM_INSTANCES;
  localparam int E_W = 2 * V_W + ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic [ADDR_W-1:0] fm_base_q, fm_base_d;
  logic [ADDR_W-1:0] w_base_q, w_base_d;
  logic [ADDR_W-1:0] issued_q, issued_d;
  logic [ADDR_W-1:0] launched_q, launched_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] fm_addr_q, fm_addr_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic              ret_vld_q, ret_vld_d;
  logic [ADDR_W-1:0] ret_idx_q, ret_idx_d;
  logic [V_W-1:0]    data_q, data_d;
  logic [V_W-1:0]    wts_q, wts_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              run_go;
  logic [ADDR_W-1:0] cfg_num, cfg_fm, cfg_w, issued_cur;
  logic              launch_fifo, launch_byp;
  logic              fifo_push, fifo_pop, fifo_next_empty;
  logic [1:0]        fifo_count;
  logic [E_W-1:0]    fifo_head, fifo_din;
  logic [2:0]        pending;
  logic              can_issue;

  // Config is used straight from the ports on the go edge so the first read issues immediately.
  assign run_go     = (state_q == ST_IDLE) && go;
  assign cfg_num    = run_go ? num_vec : num_q;
  assign cfg_fm     = run_go ? fm_base : fm_base_q;
  assign cfg_w      = run_go ? w_base  : w_base_q;
  assign issued_cur = (state_q == ST_IDLE) ? '0 : issued_q;

  // Return stage: the FIFO head is always older than data arriving from SRAM.
  assign launch_fifo = !hold && (fifo_count != 2'd0);
  assign launch_byp  = !hold && (fifo_count == 2'd0) && ret_vld_q;
  assign fifo_push   = ret_vld_q && !launch_byp;
  assign fifo_pop    = launch_fifo;
  assign fifo_din    = {fm_rd_data, w_rd_data, ret_idx_q};
  assign fifo_next_empty = (fifo_count == 2'd0 && !fifo_push) ||
                           (fifo_count == 2'd1 && fifo_pop && !fifo_push);

  // Unlaunched vectors left after this edge, before any new issue; capped at the FIFO depth.
  assign pending = {1'b0, fifo_count} + {2'b00, rd_en_q} + {2'b00, ret_vld_q}
                 - {2'b00, (launch_fifo || launch_byp)};

  assign can_issue = !hold && (run_go || state_q == ST_FETCH) &&
                     (issued_cur < cfg_num) && (pending < 3'd2);

  se_skid_fifo #(
    .W (E_W)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .count (fifo_count),
    .head  (fifo_head)
  );

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    fm_base_d  = fm_base_q;
    w_base_d   = w_base_q;
    issued_d   = issued_q;
    launched_d = launched_q;
    rd_en_d    = 1'b0;
    fm_addr_d  = fm_addr_q;
    w_addr_d   = w_addr_q;
    rd_idx_d   = rd_idx_q;
    ret_vld_d  = rd_en_q;
    ret_idx_d  = rd_idx_q;
    data_d     = data_q;
    wts_d      = wts_q;
    idx_d      = idx_q;
    start_d    = 1'b0;
    done_d     = 1'b0;

    if (state_q == ST_IDLE) begin
      issued_d   = '0;
      launched_d = '0;
    end

    if (can_issue) begin
      rd_en_d   = 1'b1;
      fm_addr_d = cfg_fm + issued_cur;
      w_addr_d  = cfg_w + issued_cur;
      rd_idx_d  = issued_cur;
      issued_d  = issued_cur + ADDR_W'(1);
    end

    if (launch_fifo) begin
      {data_d, wts_d, idx_d} = fifo_head;
      start_d    = 1'b1;
      launched_d = launched_q + ADDR_W'(1);
    end else if (launch_byp) begin
      data_d     = fm_rd_data;
      wts_d      = w_rd_data;
      idx_d      = ret_idx_q;
      start_d    = 1'b1;
      launched_d = launched_q + ADDR_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          num_d     = num_vec;
          fm_base_d = fm_base;
          w_base_d  = w_base;
          state_d   = (num_vec == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (issued_d == num_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((launched_d == num_q) && fifo_next_empty && !rd_en_d && !ret_vld_d)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      fm_base_q  <= '0;
      w_base_q   <= '0;
      issued_q   <= '0;
      launched_q <= '0;
      rd_en_q    <= 1'b0;
      fm_addr_q  <= '0;
      w_addr_q   <= '0;
      rd_idx_q   <= '0;
      ret_vld_q  <= 1'b0;
      ret_idx_q  <= '0;
      data_q     <= '0;
      wts_q      <= '0;
      idx_q      <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      fm_base_q  <= fm_base_d;
      w_base_q   <= w_base_d;
      issued_q   <= issued_d;
      launched_q <= launched_d;
      rd_en_q    <= rd_en_d;
      fm_addr_q  <= fm_addr_d;
      w_addr_q   <= w_addr_d;
      rd_idx_q   <= rd_idx_d;
      ret_vld_q  <= ret_vld_d;
      ret_idx_q  <= ret_idx_d;
      data_q     <= data_d;
      wts_q      <= wts_d;
      idx_q      <= idx_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign fm_rd_en    = rd_en_q;
  assign w_rd_en     = rd_en_q;
  assign fm_rd_addr  = fm_addr_q;
  assign w_rd_addr   = w_addr_q;
  assign data_out    = data_q;
  assign weights_out = wts_q;
  assign start_flag  = start_q;
  assign in_address  = idx_q;

endmodule

// File: tb/tb_se_mul_feeder.sv
// Directed bench for se_mul_feeder with a 1-cycle-latency SRAM model.
module tb_se_mul_feeder;

  localparam int BS = 14;
  localparam int NI = 16;
  localparam int AW = 13;
  localparam int VW = BS * NI;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go = 1'b0;
  logic [AW-1:0] num_vec = '0;
  logic [AW-1:0] fm_base = '0;
  logic [AW-1:0] w_base = '0;
  logic          hold = 1'b0;
  logic          busy, done, fm_rd_en, w_rd_en, start_flag;
  logic [AW-1:0] fm_rd_addr, w_rd_addr, in_address;
  logic [VW-1:0] fm_rd_data = '0;
  logic [VW-1:0] w_rd_data = '0;
  logic [VW-1:0] data_out, weights_out;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  int            q_idx[$];
  logic [VW-1:0] q_fm[$];
  logic [VW-1:0] q_w[$];
  int            q_sc[$];
  logic [AW-1:0] q_fa[$];
  logic [AW-1:0] q_wa[$];
  int            q_rc[$];
  int done_cnt, done_cyc, busy_cnt, max_out, en_mis;

  se_mul_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .num_vec     (num_vec),
    .fm_base     (fm_base),
    .w_base      (w_base),
    .hold        (hold),
    .busy        (busy),
    .done        (done),
    .fm_rd_en    (fm_rd_en),
    .fm_rd_addr  (fm_rd_addr),
    .fm_rd_data  (fm_rd_data),
    .w_rd_en     (w_rd_en),
    .w_rd_addr   (w_rd_addr),
    .w_rd_data   (w_rd_data),
    .data_out    (data_out),
    .weights_out (weights_out),
    .start_flag  (start_flag),
    .in_address  (in_address)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] fm_pat(input logic [AW-1:0] a);
    logic [VW-1:0] v;
    for (int i = 0; i < NI; i++) v[i*BS +: BS] = {a, 1'b0} ^ 14'(i * 37 + 1);
    return v;
  endfunction

  function automatic logic [VW-1:0] w_pat(input logic [AW-1:0] a);
    logic [VW-1:0] v;
    for (int i = 0; i < NI; i++) v[i*BS +: BS] = {1'b1, a} + 14'(i * 113);
    return v;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fm_rd_en) fm_rd_data <= fm_pat(fm_rd_addr);
    if (w_rd_en)  w_rd_data  <= w_pat(w_rd_addr);
  end

  always @(negedge clk) begin
    if (start_flag) begin
      q_idx.push_back(int'(in_address));
      q_fm.push_back(data_out);
      q_w.push_back(weights_out);
      q_sc.push_back(cyc);
    end
    if (fm_rd_en) begin
      q_fa.push_back(fm_rd_addr);
      q_wa.push_back(w_rd_addr);
      q_rc.push_back(cyc);
    end
    if (fm_rd_en !== w_rd_en) en_mis++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
    if (q_fa.size() - q_idx.size() > max_out) max_out = q_fa.size() - q_idx.size();
  end

  task automatic clear_mon();
    q_idx.delete(); q_fm.delete(); q_w.delete(); q_sc.delete();
    q_fa.delete(); q_wa.delete(); q_rc.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; max_out = 0; en_mis = 0;
  endtask

  task automatic start_run(input logic [AW-1:0] n, input logic [AW-1:0] fb,
                           input logic [AW-1:0] wb, output int c0);
    @(posedge clk); #1;
    clear_mon();
    num_vec = n; fm_base = fb; w_base = wb; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (start_flag !== 1'b0) $display("FAIL rst_start: got %b want 0", start_flag); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
    n_total++; if ({fm_rd_en, w_rd_en} !== 2'b00) $display("FAIL rst_rden: got %b want 00", {fm_rd_en, w_rd_en}); else n_pass++;
    n_total++; if ({fm_rd_addr, w_rd_addr, in_address} !== '0) $display("FAIL rst_addr: got %h want 0", {fm_rd_addr, w_rd_addr, in_address}); else n_pass++;
    n_total++; if ({data_out, weights_out} !== '0) $display("FAIL rst_data: got %h want 0", {data_out, weights_out}); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int c0;
    start_run(13'd4, 13'h100, 13'h200, c0);
    wait_done(100);
    n_total++; if (q_idx.size() !== 4) $display("FAIL basic_count: got %0d want 4", q_idx.size()); else n_pass++;
    n_total++; if (q_fa.size() !== 4) $display("FAIL basic_reads: got %0d want 4", q_fa.size()); else n_pass++;
    n_total++; if ((q_rc.size() > 0) && (q_rc[0] !== c0)) $display("FAIL basic_rd_lat: got %0d want %0d", q_rc[0], c0); else n_pass++;
    for (int i = 0; i < 4 && i < q_idx.size(); i++) begin
      n_total++; if (q_idx[i] !== i) $display("FAIL basic_idx%0d: got %0d want %0d", i, q_idx[i], i); else n_pass++;
      n_total++; if (q_sc[i] !== c0 + 2 + i) $display("FAIL basic_cyc%0d: got %0d want %0d", i, q_sc[i], c0 + 2 + i); else n_pass++;
      n_total++; if (q_fm[i] !== fm_pat(13'h100 + 13'(i))) $display("FAIL basic_fm%0d: got %h want %h", i, q_fm[i], fm_pat(13'h100 + 13'(i))); else n_pass++;
      n_total++; if (q_w[i] !== w_pat(13'h200 + 13'(i))) $display("FAIL basic_w%0d: got %h want %h", i, q_w[i], w_pat(13'h200 + 13'(i))); else n_pass++;
    end
    for (int i = 0; i < 4 && i < q_fa.size(); i++) begin
      n_total++; if (q_fa[i] !== 13'h100 + 13'(i)) $display("FAIL basic_fa%0d: got %h want %h", i, q_fa[i], 13'h100 + 13'(i)); else n_pass++;
      n_total++; if (q_wa[i] !== 13'h200 + 13'(i)) $display("FAIL basic_wa%0d: got %h want %h", i, q_wa[i], 13'h200 + 13'(i)); else n_pass++;
    end
    n_total++; if (done_cnt !== 1) $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (done_cyc !== c0 + 6) $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc, c0 + 6); else n_pass++;
    n_total++; if (en_mis !== 0) $display("FAIL basic_en_pair: got %0d want 0", en_mis); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_hold();
    int c0;
    int n = 0;
    start_run(13'd8, 13'h040, 13'h800, c0);
    while (q_idx.size() < 3 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_total++; if (start_flag !== 1'b0) $display("FAIL hold_start%0d: got %b want 0", i, start_flag); else n_pass++;
    end
    hold = 1'b0;
    n_total++; if (q_idx.size() !== 3) $display("FAIL hold_frozen: got %0d want 3", q_idx.size()); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (q_idx.size() !== 4) $display("FAIL hold_resume: got %0d want 4", q_idx.size()); else n_pass++;
    wait_done(100);
    n_total++; if (q_idx.size() !== 8) $display("FAIL hold_count: got %0d want 8", q_idx.size()); else n_pass++;
    n_total++; if (q_fa.size() !== 8) $display("FAIL hold_reads: got %0d want 8", q_fa.size()); else n_pass++;
    for (int i = 0; i < 8 && i < q_idx.size(); i++) begin
      n_total++; if (q_idx[i] !== i) $display("FAIL hold_idx%0d: got %0d want %0d", i, q_idx[i], i); else n_pass++;
      n_total++; if (q_fm[i] !== fm_pat(13'h040 + 13'(i))) $display("FAIL hold_fm%0d: got %h want %h", i, q_fm[i], fm_pat(13'h040 + 13'(i))); else n_pass++;
      n_total++; if (q_w[i] !== w_pat(13'h800 + 13'(i))) $display("FAIL hold_w%0d: got %h want %h", i, q_w[i], w_pat(13'h800 + 13'(i))); else n_pass++;
    end
    n_total++; if (max_out > 2) $display("FAIL hold_outstanding: got %0d want <=2", max_out); else n_pass++;
    n_total++; if (done_cnt !== 1) $display("FAIL hold_done_cnt: got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_zero();
    int c0;
    start_run(13'd0, 13'h055, 13'h066, c0);
    wait_done(20);
    n_total++; if (done_cnt !== 1) $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (done_cyc !== c0 + 1) $display("FAIL zero_done_cyc: got %0d want %0d", done_cyc, c0 + 1); else n_pass++;
    n_total++; if (q_fa.size() !== 0) $display("FAIL zero_reads: got %0d want 0", q_fa.size()); else n_pass++;
    n_total++; if (busy_cnt !== 0) $display("FAIL zero_busy: got %0d want 0", busy_cnt); else n_pass++;
    n_total++; if (q_idx.size() !== 0) $display("FAIL zero_launch: got %0d want 0", q_idx.size()); else n_pass++;
  endtask

  task automatic test_wrap();
    int c0;
    logic [AW-1:0] exp_fa [4];
    exp_fa[0] = 13'h1FFE; exp_fa[1] = 13'h1FFF; exp_fa[2] = 13'h0000; exp_fa[3] = 13'h0001;
    start_run(13'd4, 13'h1FFE, 13'h0FF0, c0);
    wait_done(100);
    n_total++; if (q_fa.size() !== 4) $display("FAIL wrap_reads: got %0d want 4", q_fa.size()); else n_pass++;
    for (int i = 0; i < 4 && i < q_fa.size(); i++) begin
      n_total++; if (q_fa[i] !== exp_fa[i]) $display("FAIL wrap_fa%0d: got %h want %h", i, q_fa[i], exp_fa[i]); else n_pass++;
    end
    for (int i = 0; i < 4 && i < q_idx.size(); i++) begin
      n_total++; if (q_fm[i] !== fm_pat(exp_fa[i])) $display("FAIL wrap_fm%0d: got %h want %h", i, q_fm[i], fm_pat(exp_fa[i])); else n_pass++;
    end
    n_total++; if (done_cnt !== 1) $display("FAIL wrap_done_cnt: got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c0;
    int n = 0;
    start_run(13'd16, 13'h010, 13'h020, c0);
    while (q_idx.size() < 5 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    rst = 1'b0;
    #1;
    n_total++; if ({start_flag, busy, done, fm_rd_en, w_rd_en} !== 5'b0) $display("FAIL rmid_ctrl: got %b want 00000", {start_flag, busy, done, fm_rd_en, w_rd_en}); else n_pass++;
    n_total++; if ({fm_rd_addr, w_rd_addr, in_address} !== '0) $display("FAIL rmid_addr: got %h want 0", {fm_rd_addr, w_rd_addr, in_address}); else n_pass++;
    n_total++; if ({data_out, weights_out} !== '0) $display("FAIL rmid_data: got %h want 0", {data_out, weights_out}); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    clear_mon();
    repeat (4) @(negedge clk);
    #1;
    n_total++; if (q_idx.size() + q_fa.size() + busy_cnt !== 0) $display("FAIL rmid_quiet: got %0d want 0", q_idx.size() + q_fa.size() + busy_cnt); else n_pass++;
    start_run(13'd2, 13'h300, 13'h600, c0);
    wait_done(100);
    n_total++; if (q_idx.size() !== 2) $display("FAIL rmid_count: got %0d want 2", q_idx.size()); else n_pass++;
    for (int i = 0; i < 2 && i < q_idx.size(); i++) begin
      n_total++; if (q_idx[i] !== i) $display("FAIL rmid_idx%0d: got %0d want %0d", i, q_idx[i], i); else n_pass++;
      n_total++; if (q_fm[i] !== fm_pat(13'h300 + 13'(i))) $display("FAIL rmid_fm%0d: got %h want %h", i, q_fm[i], fm_pat(13'h300 + 13'(i))); else n_pass++;
    end
    n_total++; if (done_cnt !== 1) $display("FAIL rmid_done_cnt: got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_ignored_go();
    int c0;
    start_run(13'd6, 13'h400, 13'h500, c0);
    @(posedge clk); #1;
    num_vec = 13'd3; fm_base = 13'h700; w_base = 13'h900; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    wait_done(100);
    n_total++; if (q_idx.size() !== 6) $display("FAIL igo_count: got %0d want 6", q_idx.size()); else n_pass++;
    n_total++; if (q_fa.size() !== 6) $display("FAIL igo_reads: got %0d want 6", q_fa.size()); else n_pass++;
    for (int i = 0; i < 6 && i < q_idx.size(); i++) begin
      n_total++; if (q_idx[i] !== i) $display("FAIL igo_idx%0d: got %0d want %0d", i, q_idx[i], i); else n_pass++;
      n_total++; if (q_w[i] !== w_pat(13'h500 + 13'(i))) $display("FAIL igo_w%0d: got %h want %h", i, q_w[i], w_pat(13'h500 + 13'(i))); else n_pass++;
    end
    n_total++; if (done_cnt !== 1) $display("FAIL igo_done_cnt: got %0d want 1", done_cnt); else n_pass++;
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_hold();
    test_zero();
    test_wrap();
    test_reset_mid();
    test_ignored_go();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/se_mul_feeder.md
# se_mul_feeder

Source side of the SE multiplier array's operand interface. It reads 16-lane feature and weight vectors from the SE feature buffer and the SE weight SRAM, and drives `data_out`, `weights_out`, `start_flag` and `in_address` into the multiplier top, one vector per cycle. It owns run sequencing (go/busy/done), the SRAM read addressing and a 2-entry skid FIFO that absorbs the 1-cycle SRAM read latency under `hold` back-pressure.

## Interface
- `BITSIZE`, 14: width of one lane element (Q-format integer + FRAC bits).
- `NUM_INSTANCES`, 16: lanes per vector.
- `ADDR_W`, 13: width of SRAM addresses and of the vector index.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `go`  in  1  one-cycle start pulse; honoured only in IDLE.
- `num_vec`  in  ADDR_W  vectors in the run; latched on `go`.
- `fm_base`, `w_base`  in  ADDR_W each  base read addresses; latched on `go`.
- `hold`  in  1  downstream stall; sampled each edge.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle end-of-run pulse.
- `fm_rd_en`  out  1  feature SRAM read strobe.
- `fm_rd_addr`  out  ADDR_W  feature SRAM address.
- `fm_rd_data`  in  BITSIZE*NUM_INSTANCES  feature read data, valid 1 cycle after the strobe.
- `w_rd_en`, `w_rd_addr`, `w_rd_data`: weight SRAM read port, identical rules to the feature port.
- `data_out`, `weights_out`  out  BITSIZE*NUM_INSTANCES each  operands to the multiplier.
- `start_flag`  out  1  operands valid this cycle.
- `in_address`  out  ADDR_W  vector index 0..num_vec-1 for the operands.

## Operation
- **Reset values:** every output is 0. State is IDLE. FIFO, counters and the in-flight flag are cleared.
- **Registers:** all outputs are registered. There is no combinational path from any input to any output.

State machine (IDLE, FETCH, DRAIN, DONE):
- **IDLE:** when `go`=1:
  - latch the config;
  - if `num_vec`=0, go to DONE;
  - otherwise go to FETCH with `busy`=1.
- **FETCH:** a read is issued on an edge iff all of the following hold: `hold`=0, issued<`num_vec`, and fifo_count + inflight < 2.
  - An issue sets `fm_rd_en`=`w_rd_en`=1 for the next cycle, with addresses base+issue_idx.
  - Both ports are always strobed together with equal offsets.
  - Go to DRAIN when issued=`num_vec`.
- **Data return:** returned data plus its index is written to the FIFO.
  - Bypass: if the FIFO is empty and `hold`=0, the data loads the output register directly.
- **Output launch:** on each edge with `hold`=0 and data available (FIFO head or bypass), load `data_out`, `weights_out`, `in_address` and set `start_flag`=1 for one cycle. Otherwise `start_flag`=0.
  - Operand and index values are held (not zeroed) while `start_flag`=0.
- **DRAIN:** go to DONE when launched=`num_vec`, FIFO is empty and nothing is in flight.
- **DONE:** `done`=1 for one cycle, `busy`=0, return to IDLE.
- **Ordering:** `in_address` strictly increments from 0. No vector is dropped or duplicated under any `hold` pattern.
- **Width rules:** address = base+index modulo 2^ADDR_W (wraps silently). Data passes through unmodified, with no arithmetic on it.
- **Boundary cases:**
  - `go` while busy is ignored.
  - `hold` held indefinitely: FIFO holds ≤2 entries and never overflows.
  - `rst` low mid-run: immediate return to IDLE and all outputs 0. In-flight SRAM data is discarded.

## Timing
- `go` sampled at edge E0: `fm_rd_en`=1 in cycle E0→E1, data valid E1→E2, `start_flag` first high in E2→E3. Latency is 2 edges.
- Steady state with `hold`=0: 1 vector/cycle, one read in flight, FIFO empty.
- `hold`=1 at edge Eh: no launch and no issue at Eh. The in-flight read lands in the FIFO.
  - Release at edge Er: launch from the FIFO at Er.
  - Issue resumes at Er if fifo+inflight<2, else 1 edge later.
- `done` is high the cycle after the last `start_flag` cycle's drain condition is met: minimum 1 cycle after the last `start_flag`.
- `num_vec`=0: `done` is high in E1→E2, with no read strobes.

## Structure
- **Shared package `se_pkg`:**
  - constants BITSIZE=14, FRAC_BITS=7, NUM_INSTANCES=16, ADDR_W=13;
  - FSM state encoding (IDLE=0, FETCH=1, DRAIN=2, DONE=3).
- **Sub-module `se_skid_fifo`:** 2-entry FIFO, width 2*BITSIZE*NUM_INSTANCES+ADDR_W.
  - Ports: push, pop, count[1:0], head.
  - Async active-low reset.
- **Top-level logic:** FSM, issue/launch counters and the bypass mux.

## Test plan
- **Basic run:** `num_vec`=4, `fm_base`=0x100, `w_base`=0x200, `hold`=0 → reads at 0x100..0x103 and 0x200..0x203. `start_flag` high 4 consecutive cycles starting 2 edges after `go`. `in_address` 0,1,2,3. `done` pulses once.
- **Hold mid-run:** `num_vec`=8 with `hold`=1 for 5 cycles after the 3rd launch → exactly 8 launches, indices 0..7 in order. FIFO count never exceeds 2. No `rd_en` while fifo+inflight=2.
- **Zero-length run:** `num_vec`=0 → `done` at E1→E2, `busy` never high, no read strobes.
- **Address wrap:** `fm_base`=0x1FFE, `num_vec`=4 → `fm_rd_addr` 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- **Reset mid-run:** `rst` low during run of 16 after 5 launches → all outputs 0 immediately. A new `go` with `num_vec`=2 then launches indices 0,1 only.
- **Ignored go:** `go` pulsed again while busy → no effect. Launch count equals the original `num_vec`=6.
